// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: in-order issue queue and sequencer for the FPU operand/result port.
// Issues one op at a time, times it by class latency and hands the result to writeback.
module fpu_issue_ctrl #(
  parameter int DEPTH      = 4,
  parameter int LAT_ADD    = 4,
  parameter int LAT_MUL    = 4,
  parameter int LAT_DIV    = 28,
  parameter int LAT_FMA    = 7,
  parameter int LAT_SIMPLE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [6:0]  in_funct7,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs2f,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic [31:0] in_op3,
  output logic [6:0]  fpu_opcode,
  output logic [6:0]  fpu_funct7,
  output logic [2:0]  fpu_funct3,
  output logic [4:0]  fpu_rs2f,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [31:0] fpu_rs3,
  output logic        fpu_start,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_fflags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_fflags,
  output logic        wb_illegal,
  output logic        busy
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = 8;
  localparam int EW   = 7 + 7 + 3 + 5 + 5 + 96;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [1:0]      state;
  logic [CNTW-1:0] cnt, head_lat;
  logic            head_illegal, push, capture, active;

  logic [6:0]  h_opcode, h_funct7;
  logic [2:0]  h_funct3;
  logic [4:0]  h_rs2f, h_rd;
  logic [31:0] h_op1, h_op2, h_op3;

  assign {h_opcode, h_funct7, h_funct3, h_rs2f, h_rd, h_op1, h_op2, h_op3} = mem[rd_ptr];

  assign push       = in_valid && in_ready;
  assign capture    = (state == S_WAIT) && (cnt == '0) && (!wb_valid || wb_ready);
  assign count_next = count + CW'(push) - CW'(capture);
  assign in_ready   = (count != CW'(DEPTH));
  assign active     = (state != S_IDLE);
  assign fpu_start  = (state == S_ISSUE);
  assign busy       = (count != '0) || active || wb_valid;

  // The FPU has no handshake, so its inputs are forced to zero whenever nothing is issued.
  assign fpu_opcode = active ? h_opcode : 7'd0;
  assign fpu_funct7 = active ? h_funct7 : 7'd0;
  assign fpu_funct3 = active ? h_funct3 : 3'd0;
  assign fpu_rs2f   = active ? h_rs2f   : 5'd0;
  assign fpu_rs1    = active ? h_op1    : 32'd0;
  assign fpu_rs2    = active ? h_op2    : 32'd0;
  assign fpu_rs3    = active ? h_op3    : 32'd0;

  always_comb begin
    head_illegal = 1'b0;
    head_lat     = CNTW'(LAT_SIMPLE);
    case (h_opcode)
      7'b1010011: begin
        case (h_funct7)
          7'b0000000, 7'b0000100: head_lat = CNTW'(LAT_ADD);
          7'b0001000:             head_lat = CNTW'(LAT_MUL);
          7'b0001100, 7'b0101100: head_lat = CNTW'(LAT_DIV);
          default:                head_lat = CNTW'(LAT_SIMPLE);
        endcase
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: head_lat = CNTW'(LAT_FMA);
      default: head_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_opcode, in_funct7, in_funct3, in_rs2f, in_rd, in_op1, in_op2, in_op3};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (capture) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // A capture that leaves work queued goes straight back to ISSUE, skipping IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (count != '0) state <= S_ISSUE;
        S_ISSUE: begin
          cnt   <= head_lat - CNTW'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNTW'(1);
          else if (capture) state <= (count_next != '0) ? S_ISSUE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_fflags  <= '0;
      wb_illegal <= 1'b0;
    end else if (capture) begin
      wb_valid   <= 1'b1;
      wb_rd      <= h_rd;
      wb_data    <= head_illegal ? 32'd0 : fpu_result;
      wb_fflags  <= head_illegal ? 5'b10000 : fpu_fflags;
      wb_illegal <= head_illegal;
    end else if (wb_valid && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized and directed bench for fpu_issue_ctrl against a
// time-based reference model (op issued at cycle T completes at T+lat or later if stalled).
module tb_fpu_issue_ctrl;
  localparam int DEPTH = 4, LAT_ADD = 4, LAT_MUL = 4, LAT_DIV = 28, LAT_FMA = 7, LAT_SIMPLE = 1;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs2f;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
  } instr_t;

  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, wb_ready = 1'b0;
  logic in_ready, fpu_start, wb_valid, wb_illegal, busy;
  logic [6:0] in_opcode = '0, in_funct7 = '0, fpu_opcode, fpu_funct7;
  logic [2:0] in_funct3 = '0, fpu_funct3;
  logic [4:0] in_rs2f = '0, in_rd = '0, fpu_rs2f, fpu_fflags, wb_rd, wb_fflags;
  logic [31:0] in_op1 = '0, in_op2 = '0, in_op3 = '0;
  logic [31:0] fpu_rs1, fpu_rs2, fpu_rs3, fpu_result, wb_data;
  logic [36:0] fpu_out;

  int errors = 0, checks = 0, cyc = 0;
  logic chk_en = 1'b0, saw_full = 1'b0;
  logic [4:0] got_rd[$];

  instr_t mq[$];
  logic m_active = 1'b0, m_wbv = 1'b0, m_ill = 1'b0;
  int m_tissue = 0, n = 0;
  logic [4:0] m_rd = '0, m_flags = '0;
  logic [31:0] m_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_issue_ctrl #(.DEPTH(DEPTH), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
                   .LAT_FMA(LAT_FMA), .LAT_SIMPLE(LAT_SIMPLE)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rs2f(in_rs2f),
    .in_rd(in_rd), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
    .fpu_opcode(fpu_opcode), .fpu_funct7(fpu_funct7), .fpu_funct3(fpu_funct3), .fpu_rs2f(fpu_rs2f),
    .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_rs3(fpu_rs3), .fpu_start(fpu_start),
    .fpu_result(fpu_result), .fpu_fflags(fpu_fflags), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_fflags(wb_fflags), .wb_illegal(wb_illegal), .busy(busy)
  );

  // Stand-in FPU: real answers for the directed cases, a field-mixing hash otherwise.
  function automatic logic [36:0] fake_fpu(logic [6:0] opc, logic [6:0] f7, logic [2:0] f3,
                                           logic [4:0] rs2f, logic [31:0] a, logic [31:0] b,
                                           logic [31:0] c);
    logic [31:0] r;
    if (opc == 7'b1010011 && f7 == 7'b0000000 && a == 32'h3F800000 && b == 32'h40000000)
      return {5'd0, 32'h40400000};
    if (opc == 7'b1010011 && f7 == 7'b0001100 && a == 32'h40C00000 && b == 32'h40000000)
      return {5'd0, 32'h40400000};
    if (opc == 7'b1010011 && f7 == 7'b0010000 && f3 == 3'b000)
      return {5'd0, b[31], a[30:0]};
    r = a ^ {b[15:0], b[31:16]} ^ (c >> 3) ^ {f7, f3, rs2f, opc, 10'h0};
    return {r[4:0] ^ r[31:27], r};
  endfunction

  assign fpu_out    = fake_fpu(fpu_opcode, fpu_funct7, fpu_funct3, fpu_rs2f, fpu_rs1, fpu_rs2, fpu_rs3);
  assign fpu_fflags = fpu_out[36:32];
  assign fpu_result = fpu_out[31:0];

  function automatic logic is_illegal(instr_t i);
    return !(i.opcode == 7'b1010011 || i.opcode == 7'b1000011 || i.opcode == 7'b1000111 ||
             i.opcode == 7'b1001011 || i.opcode == 7'b1001111);
  endfunction

  function automatic int lat_of(instr_t i);
    if (i.opcode == 7'b1010011) begin
      if (i.funct7 == 7'b0000000 || i.funct7 == 7'b0000100) return LAT_ADD;
      if (i.funct7 == 7'b0001000) return LAT_MUL;
      if (i.funct7 == 7'b0001100 || i.funct7 == 7'b0101100) return LAT_DIV;
      return LAT_SIMPLE;
    end
    if (!is_illegal(i)) return LAT_FMA;
    return LAT_SIMPLE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    instr_t h;
    logic done, was_ne;
    logic [36:0] fr;
    h = (mq.size() > 0) ? mq[0] : '0;
    if (chk_en) begin
      checkOutput("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      checkOutput("busy", 32'(busy), 32'(mq.size() > 0 || m_wbv));
      checkOutput("fpu_start", 32'(fpu_start), 32'(m_active && n == m_tissue));
      checkOutput("fpu_opcode", 32'(fpu_opcode), 32'(m_active ? h.opcode : 7'd0));
      checkOutput("fpu_funct7", 32'(fpu_funct7), 32'(m_active ? h.funct7 : 7'd0));
      checkOutput("fpu_funct3", 32'(fpu_funct3), 32'(m_active ? h.funct3 : 3'd0));
      checkOutput("fpu_rs2f", 32'(fpu_rs2f), 32'(m_active ? h.rs2f : 5'd0));
      checkOutput("fpu_rs1", fpu_rs1, m_active ? h.op1 : 32'd0);
      checkOutput("fpu_rs2", fpu_rs2, m_active ? h.op2 : 32'd0);
      checkOutput("fpu_rs3", fpu_rs3, m_active ? h.op3 : 32'd0);
      checkOutput("wb_valid", 32'(wb_valid), 32'(m_wbv));
      checkOutput("wb_rd", 32'(wb_rd), 32'(m_rd));
      checkOutput("wb_data", wb_data, m_data);
      checkOutput("wb_fflags", 32'(wb_fflags), 32'(m_flags));
      checkOutput("wb_illegal", 32'(wb_illegal), 32'(m_ill));
      if (wb_valid && wb_ready) got_rd.push_back(wb_rd);
      if (!in_ready) saw_full = 1'b1;
    end
    if (!resetn) begin
      mq.delete();
      m_active = 1'b0; m_wbv = 1'b0; m_ill = 1'b0;
      m_rd = '0; m_data = '0; m_flags = '0;
    end else begin
      done   = m_active && (n >= m_tissue + lat_of(h)) && (!m_wbv || wb_ready);
      was_ne = mq.size() > 0;
      if (done) begin
        fr      = fake_fpu(h.opcode, h.funct7, h.funct3, h.rs2f, h.op1, h.op2, h.op3);
        m_wbv   = 1'b1;
        m_rd    = h.rd;
        m_ill   = is_illegal(h);
        m_data  = m_ill ? 32'd0 : fr[31:0];
        m_flags = m_ill ? 5'b10000 : fr[36:32];
      end else if (m_wbv && wb_ready) begin
        m_wbv = 1'b0;
      end
      if (in_valid && mq.size() < DEPTH)
        mq.push_back({in_opcode, in_funct7, in_funct3, in_rs2f, in_rd, in_op1, in_op2, in_op3});
      if (done) begin
        void'(mq.pop_front());
        m_active = mq.size() > 0;
        m_tissue = n + 1;
      end else if (!m_active && was_ne) begin
        m_active = 1'b1;
        m_tissue = n + 1;
      end
    end
    n++;
  end

  function automatic instr_t mk(logic [6:0] opc, logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
                                logic [31:0] a, logic [31:0] b);
    return {opc, f7, f3, 5'd0, rd, a, b, 32'h0};
  endfunction

  function automatic instr_t rand_instr(logic [4:0] rd);
    instr_t i;
    i = {7'b1010011, 7'd0, 3'($urandom), 5'($urandom), rd, $urandom, $urandom, $urandom};
    case ($urandom % 10)
      0: i.funct7 = 7'b0000000;
      1: i.funct7 = 7'b0000100;
      2: i.funct7 = 7'b0001000;
      3: i.funct7 = 7'b0001100;
      4: i.funct7 = 7'b0101100;
      5: i.funct7 = 7'($urandom);
      6: i.opcode = 7'b1000011;
      7: i.opcode = ($urandom % 2) ? 7'b1000111 : 7'b1001011;
      8: i.opcode = 7'b1001111;
      default: i.opcode = ($urandom % 2) ? 7'b0110011 : 7'b0000011;
    endcase
    return i;
  endfunction

  task automatic driveInstr(input instr_t i);
    {in_opcode, in_funct7, in_funct3, in_rs2f, in_rd, in_op1, in_op2, in_op3} = i;
  endtask

  task automatic applyStimulus(input instr_t i);
    logic ok;
    ok = 1'b0;
    driveInstr(i);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("push_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitStart(output int c);
    c = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fpu_start) begin c = cyc; break; end
    end
    if (c < 0) checkOutput("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitWb(output int c);
    c = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wb_valid) begin c = cyc; break; end
    end
    if (c < 0) checkOutput("wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitResults(input int cnt);
    for (int k = 0; k < 400 && got_rd.size() < cnt; k++) @(negedge clk);
    checkOutput("result_count", 32'(got_rd.size()), 32'(cnt));
  endtask

  initial begin
    int s, w;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_fpu_opcode", 32'(fpu_opcode), 32'd0);
    @(posedge clk); #1;

    wb_ready = 1'b1;
    applyStimulus(mk(7'b1010011, 7'b0000000, 3'b000, 5'd3, 32'h3F800000, 32'h40000000));
    waitStart(s);
    waitWb(w);
    checkOutput("fadd_start_to_wb", 32'(w - s), 32'(LAT_ADD + 1));
    checkOutput("fadd_data", wb_data, 32'h40400000);
    @(negedge clk);
    checkOutput("fadd_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    applyStimulus(mk(7'b1010011, 7'b0001100, 3'b000, 5'd4, 32'h40C00000, 32'h40000000));
    waitStart(s);
    waitWb(w);
    checkOutput("fdiv_start_to_wb", 32'(w - s), 32'(LAT_DIV + 1));
    checkOutput("fdiv_data", wb_data, 32'h40400000);
    @(posedge clk); #1;

    got_rd.delete();
    saw_full = 1'b0;
    for (int i = 1; i <= 5; i++)
      applyStimulus(mk(7'b1010011, 7'b0001000, 3'b000, 5'(i), $urandom, $urandom));
    waitResults(5);
    checkOutput("qfill_saw_full", 32'(saw_full), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < got_rd.size()) checkOutput("qfill_rd_order", 32'(got_rd[i]), 32'(i + 1));
    @(posedge clk); #1;

    wb_ready = 1'b0;
    applyStimulus(mk(7'b1010011, 7'b0010000, 3'b000, 5'd7, 32'h3F800000, 32'hC0000000));
    applyStimulus(mk(7'b1010011, 7'b0000000, 3'b000, 5'd8, 32'h3F800000, 32'h40000000));
    waitWb(w);
    for (int k = 0; k < 6; k++) begin
      checkOutput("bp_hold_data", wb_data, 32'hBF800000);
      checkOutput("bp_hold_rd", 32'(wb_rd), 32'd7);
      @(negedge clk);
    end
    got_rd.delete();
    @(posedge clk); #1;
    wb_ready = 1'b1;
    waitResults(2);
    for (int i = 0; i < 2; i++)
      if (i < got_rd.size()) checkOutput("bp_rd_order", 32'(got_rd[i]), 32'(i + 7));
    @(posedge clk); #1;

    applyStimulus(mk(7'b1010011, 7'b0001100, 3'b000, 5'd10, 32'h40C00000, 32'h40000000));
    waitStart(s);
    repeat (9) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_fpu_start", 32'(fpu_start), 32'd0);
    @(posedge clk); #1;
    applyStimulus(mk(7'b1010011, 7'b0000000, 3'b000, 5'd11, 32'h3F800000, 32'h40000000));
    waitWb(w);
    checkOutput("rst_after_fadd_data", wb_data, 32'h40400000);
    checkOutput("rst_after_fadd_rd", 32'(wb_rd), 32'd11);
    @(posedge clk); #1;

    applyStimulus(mk(7'b0110011, 7'b0000000, 3'b000, 5'd9, $urandom, $urandom));
    waitStart(s);
    waitWb(w);
    checkOutput("illegal_start_to_wb", 32'(w - s), 32'(LAT_SIMPLE + 1));
    checkOutput("illegal_flag", 32'(wb_illegal), 32'd1);
    checkOutput("illegal_data", wb_data, 32'd0);
    checkOutput("illegal_fflags", 32'(wb_fflags), 32'h10);
    @(posedge clk); #1;

    for (int k = 0; k < 1500; k++) begin
      wb_ready = ($urandom % 4) != 0;
      resetn   = ($urandom % 300) != 0;
      in_valid = ($urandom % 2) == 1;
      driveInstr(rand_instr(5'($urandom)));
      @(posedge clk); #1;
    end
    resetn   = 1'b1;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int k = 0; k < 500 && busy; k++) @(negedge clk);
    @(negedge clk);
    checkOutput("drain_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
